// File: rtl/axi4_burst_slave.sv
// AXI4 memory-mapped burst slave with an integrated word-addressed memory.
// Independent write and read FSMs, one outstanding burst each, FIXED/INCR/WRAP bursts.
module axi4_burst_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int         BYTES       = DATA_WIDTH / 8;
  localparam int         SHIFT       = $clog2(BYTES);
  localparam int         IDX_W       = $clog2(MEMORY_DEPTH);
  localparam logic [2:0] SIZE_OK     = 3'(SHIFT);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Byte mask selecting the offset inside a WRAP window of (len+1) beats.
  function automatic logic [ADDR_WIDTH-1:0] wrap_mask(input logic [7:0] len);
    return ADDR_WIDTH'((32'(len) + 32'd1) * 32'(BYTES) - 32'd1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [1:0]            burst,
    input logic [ADDR_WIDTH-1:0] mask
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] result;
    inc = addr + ADDR_WIDTH'(BYTES);
    case (burst)
      BURST_INCR:  result = inc;
      BURST_WRAP:  result = (addr & ~mask) | (inc & mask);
      BURST_FIXED: result = addr;
      default:     result = addr;
    endcase
    return result;
  endfunction

  function automatic logic req_error(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [31:0] last_byte;
    logic        err;
    err = (size != SIZE_OK) || (burst == BURST_RSVD);
    if (burst == BURST_WRAP) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
      if ((addr & ADDR_WIDTH'(BYTES - 1)) != '0) err = 1'b1;
    end
    // Highest byte any beat can touch: last INCR beat, or top of the WRAP window.
    case (burst)
      BURST_INCR: last_byte = 32'(addr) + 32'(len) * 32'(BYTES);
      BURST_WRAP: last_byte = 32'(addr | wrap_mask(len));
      default:    last_byte = 32'(addr);
    endcase
    if ((last_byte >> SHIFT) >= 32'(MEMORY_DEPTH)) err = 1'b1;
    return err;
  endfunction

  logic                  live;
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr, w_mask;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_req_err, w_last_err;
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_mask;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_req_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  aw_hs, w_hs, ar_hs, r_hs;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;
  assign w_idx = IDX_W'(w_addr >> SHIFT);
  assign r_idx = IDX_W'(r_addr >> SHIFT);

  // NOTE: every output and next-state gets a default first so no latch is inferred.
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    if (live) begin
      case (w_state)
        W_IDLE: begin
          AWREADY = 1'b1;
          if (AWVALID) w_next = W_DATA;
        end
        W_DATA: begin
          WREADY = 1'b1;
          if (WVALID && (w_cnt == w_len)) w_next = W_RESP;
        end
        W_RESP: begin
          BVALID = 1'b1;
          BRESP  = (w_req_err || w_last_err) ? RESP_SLVERR : RESP_OKAY;
          if (BREADY) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RDATA   = '0;
    RRESP   = RESP_OKAY;
    RLAST   = 1'b0;
    if (live) begin
      case (r_state)
        R_IDLE: begin
          ARREADY = 1'b1;
          if (ARVALID) r_next = R_FETCH;
        end
        R_FETCH: r_next = R_DATA;
        R_DATA: begin
          RVALID = 1'b1;
          RDATA  = r_data;
          RRESP  = r_req_err ? RESP_SLVERR : RESP_OKAY;
          RLAST  = (r_cnt == r_len);
          if (RREADY) r_next = (r_cnt == r_len) ? R_IDLE : R_FETCH;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      live       <= 1'b0;
      w_state    <= W_IDLE;
      w_addr     <= '0;
      w_mask     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_burst    <= '0;
      w_req_err  <= 1'b0;
      w_last_err <= 1'b0;
    end else begin
      live    <= 1'b1;
      w_state <= w_next;
      if (aw_hs) begin
        w_addr     <= AWADDR;
        w_len      <= AWLEN;
        w_burst    <= AWBURST;
        w_mask     <= wrap_mask(AWLEN);
        w_cnt      <= '0;
        w_req_err  <= req_error(AWADDR, AWLEN, AWSIZE, AWBURST);
        w_last_err <= 1'b0;
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_burst, w_mask);
        w_cnt  <= w_cnt + 8'd1;
        if (WLAST != (w_cnt == w_len)) w_last_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_req_err <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_addr    <= ARADDR;
        r_len     <= ARLEN;
        r_burst   <= ARBURST;
        r_mask    <= wrap_mask(ARLEN);
        r_cnt     <= '0;
        r_req_err <= req_error(ARADDR, ARLEN, ARSIZE, ARBURST);
      end else if (r_hs) begin
        r_addr <= next_addr(r_addr, r_burst, r_mask);
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  // NOTE: the memory array is deliberately not reset so contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_hs && !w_req_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
    if (r_state == R_FETCH) r_data <= r_req_err ? '0 : mem[r_idx];
  end

endmodule
